// File: rtl/winograd_dot_stream.sv
// Streaming Winograd inner-product engine: pre-add, multiply and accumulate over a packet,
// with optional removal of the a*a / b*b cross terms to return the exact dot product.
module winograd_dot_stream #(
    parameter int IN_SIZE_0 = 8,
    parameter int IN_SIZE_1 = 8,
    parameter int N_PAIRS   = 4,
    parameter int MAX_BEATS = 16,
    localparam int W     = (IN_SIZE_0 > IN_SIZE_1) ? IN_SIZE_0 : IN_SIZE_1,
    localparam int PW    = 2 * (W + 1),
    localparam int CW    = $clog2(MAX_BEATS + 1),
    localparam int ACC_W = PW + $clog2(N_PAIRS * MAX_BEATS) + 2
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             in_valid_i,
    output logic                             in_ready_o,
    input  logic                             in_last_i,
    input  logic                             mode_i,
    input  logic [2*N_PAIRS*IN_SIZE_0-1:0]   in_0_i,
    input  logic [2*N_PAIRS*IN_SIZE_1-1:0]   in_1_i,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic [ACC_W-1:0]                 out_o,
    output logic [CW-1:0]                    out_beats_o,
    output logic                             out_trunc_o
);

    typedef enum logic [1:0] {ACC, DRAIN, OUT} state_t;

    function automatic logic signed [W:0] sext_a(input logic [IN_SIZE_0-1:0] x);
        return $signed({{(W + 1 - IN_SIZE_0){x[IN_SIZE_0-1]}}, x});
    endfunction

    function automatic logic signed [W:0] sext_b(input logic [IN_SIZE_1-1:0] x);
        return $signed({{(W + 1 - IN_SIZE_1){x[IN_SIZE_1-1]}}, x});
    endfunction

    function automatic logic signed [PW-1:0] smul(input logic signed [W:0] x,
                                                  input logic signed [W:0] y);
        return PW'(x) * PW'(y);
    endfunction

    state_t                   state_q, state_d;
    logic [1:0]               dcnt_q;
    logic [CW-1:0]            cnt_q;
    logic                     trunc_q;
    logic                     mode_q;
    logic                     vld_p1, vld_p2;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  sum_p2;

    logic signed [W:0]        pa_p1 [N_PAIRS];
    logic signed [W:0]        pb_p1 [N_PAIRS];
    logic signed [W:0]        ea_p1 [2*N_PAIRS];
    logic signed [W:0]        eb_p1 [2*N_PAIRS];
    logic signed [PW-1:0]     prod_p2 [N_PAIRS];
    logic signed [PW-1:0]     ca_p2 [N_PAIRS];
    logic signed [PW-1:0]     cb_p2 [N_PAIRS];

    logic beat_acc, out_hs, at_max;

    assign in_ready_o  = (state_q == ACC);
    assign beat_acc    = in_valid_i && in_ready_o;
    assign out_valid_o = (state_q == OUT);
    assign out_hs      = out_valid_o && out_ready_i;
    assign at_max      = (cnt_q == CW'(MAX_BEATS - 1));

    assign out_o       = out_valid_o ? acc_q : '0;
    assign out_beats_o = out_valid_o ? cnt_q : '0;
    assign out_trunc_o = out_valid_o ? trunc_q : 1'b0;

    // S1: sign-extended pre-adds and raw elements for the correction terms
    always_ff @(posedge clk_i) begin
        if (beat_acc) begin
            for (int j = 0; j < N_PAIRS; j++) begin
                pa_p1[j] <= sext_a(in_0_i[(2*j+1)*IN_SIZE_0 +: IN_SIZE_0])
                          + sext_b(in_1_i[(2*j)*IN_SIZE_1 +: IN_SIZE_1]);
                pb_p1[j] <= sext_a(in_0_i[(2*j)*IN_SIZE_0 +: IN_SIZE_0])
                          + sext_b(in_1_i[(2*j+1)*IN_SIZE_1 +: IN_SIZE_1]);
            end
            for (int k = 0; k < 2*N_PAIRS; k++) begin
                ea_p1[k] <= sext_a(in_0_i[k*IN_SIZE_0 +: IN_SIZE_0]);
                eb_p1[k] <= sext_b(in_1_i[k*IN_SIZE_1 +: IN_SIZE_1]);
            end
        end
    end

    // S2: Winograd products and cross-term products
    always_ff @(posedge clk_i) begin
        if (vld_p1) begin
            for (int j = 0; j < N_PAIRS; j++) begin
                prod_p2[j] <= smul(pa_p1[j], pb_p1[j]);
                ca_p2[j]   <= smul(ea_p1[2*j], ea_p1[2*j+1]);
                cb_p2[j]   <= smul(eb_p1[2*j], eb_p1[2*j+1]);
            end
        end
    end

    // S3: adder tree feeding the accumulator
    always_comb begin
        sum_p2 = '0;
        for (int j = 0; j < N_PAIRS; j++) begin
            sum_p2 = sum_p2 + ACC_W'(prod_p2[j]);
            if (mode_q) begin
                sum_p2 = sum_p2 - ACC_W'(ca_p2[j]) - ACC_W'(cb_p2[j]);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACC:     if (beat_acc && (in_last_i || at_max)) state_d = DRAIN;
            DRAIN:   if (dcnt_q == 2'd3) state_d = OUT;
            OUT:     if (out_ready_i) state_d = ACC;
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ACC;
            dcnt_q  <= '0;
            cnt_q   <= '0;
            trunc_q <= 1'b0;
            mode_q  <= 1'b0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= (state_q == DRAIN) ? dcnt_q + 2'd1 : 2'd0;
            vld_p1  <= beat_acc;
            vld_p2  <= vld_p1;
            if (beat_acc && cnt_q == '0) mode_q <= mode_i;
            if (out_hs) begin
                cnt_q   <= '0;
                trunc_q <= 1'b0;
                acc_q   <= '0;
            end else begin
                if (beat_acc && cnt_q != CW'(MAX_BEATS)) cnt_q <= cnt_q + CW'(1);
                if (beat_acc && at_max && !in_last_i) trunc_q <= 1'b1;
                if (vld_p2) acc_q <= acc_q + sum_p2;
            end
        end
    end

endmodule

// File: tb/tb_winograd_dot_stream.sv
// Directed and randomized bench for winograd_dot_stream against an arithmetic dot-product model.
module tb_winograd_dot_stream;

    localparam int MB    = 4;
    localparam int ACC_W = 18 + $clog2(4 * MB) + 2;
    localparam int CW    = $clog2(MB + 1);

    logic              clk = 1'b0;
    logic              rst_ni;
    logic              in_valid, in_ready, in_last, mode_in;
    logic [63:0]       in_0, in_1;
    logic              out_valid, out_ready;
    logic [ACC_W-1:0]  out_o;
    logic [CW-1:0]     out_beats;
    logic              out_trunc;

    int n_tests = 0;
    int n_fail  = 0;

    winograd_dot_stream #(
        .IN_SIZE_0(8), .IN_SIZE_1(8), .N_PAIRS(4), .MAX_BEATS(MB)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_last_i(in_last),
        .mode_i(mode_in), .in_0_i(in_0), .in_1_i(in_1),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_o(out_o), .out_beats_o(out_beats), .out_trunc_o(out_trunc)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Exact mode is the plain dot product; raw mode is the Winograd pair sum.
    function automatic longint beat_val(input logic [63:0] a, input logic [63:0] b,
                                        input bit mode);
        longint s = 0;
        int ae [8];
        int be [8];
        for (int k = 0; k < 8; k++) begin
            ae[k] = int'($signed(a[k*8 +: 8]));
            be[k] = int'($signed(b[k*8 +: 8]));
        end
        if (mode) begin
            for (int k = 0; k < 8; k++) s += longint'(ae[k] * be[k]);
        end else begin
            for (int j = 0; j < 4; j++)
                s += longint'((ae[2*j+1] + be[2*j]) * (ae[2*j] + be[2*j+1]));
        end
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [63:0] a, input logic [63:0] b,
                             input bit last, input bit mode);
        int w = 0;
        in_0 = a; in_1 = b; in_last = last; mode_in = mode; in_valid = 1'b1;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        chk("in_ready_wait", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic get_result(input string tag, input longint exp_o, input int exp_b,
                              input bit exp_t, input int stall);
        int w = 0;
        while (!out_valid && w < 50) begin
            tick();
            w++;
        end
        chk({tag, "_valid"}, out_valid, 1);
        repeat (stall) tick();
        chk({tag, "_out"}, $signed(out_o), exp_o);
        chk({tag, "_beats"}, out_beats, exp_b);
        chk({tag, "_trunc"}, out_trunc, exp_t);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_valid_clr"}, out_valid, 0);
    endtask

    task automatic run_packet(input int len, input bit mode, input int gaps);
        longint exp = 0;
        logic [63:0] a, b;
        for (int i = 0; i < len; i++) begin
            repeat ($urandom_range(0, gaps)) tick();
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            exp += beat_val(a, b, mode);
            send_beat(a, b, i == len - 1, (i == 0) ? mode : 1'($urandom));
        end
        get_result("T2", exp, len, 1'b0, $urandom_range(0, 3));
    endtask

    initial begin
        logic [63:0] ones, twos, qa, qb, pa, pb;
        longint exp_p;
        bit qm;
        ones = 64'h0101010101010101;
        twos = 64'h0202020202020202;
        rst_ni = 1'b0; in_valid = 1'b0; in_last = 1'b0; mode_in = 1'b0;
        in_0 = '0; in_1 = '0; out_ready = 1'b0;

        // Reset state
        repeat (2) tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", $signed(out_o), 0);
        chk("rst_beats", out_beats, 0);
        chk("rst_trunc", out_trunc, 0);
        rst_ni = 1'b1;
        tick();

        // T1: exact mode, latency 4 cycles from the accepting edge
        send_beat(ones, twos, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("T1_latency_low", out_valid, 0);
            chk("T1_in_ready_low", in_ready, 0);
            tick();
        end
        chk("T1_latency_high", out_valid, 1);
        get_result("T1", 16, 1, 1'b0, 0);
        chk("T1_in_ready_back", in_ready, 1);

        // T1b: raw mode
        send_beat(ones, twos, 1'b1, 1'b0);
        get_result("T1b", 36, 1, 1'b0, 1);

        // T3: extreme operands in exact mode
        send_beat(64'h8080808080808080, 64'h8080808080808080, 1'b1, 1'b1);
        get_result("T3_neg", 131072, 1, 1'b0, 0);
        send_beat(64'h7f7f7f7f7f7f7f7f, 64'h7f7f7f7f7f7f7f7f, 1'b1, 1'b1);
        get_result("T3_pos", 129032, 1, 1'b0, 0);
        send_beat(64'h7f7f7f7f7f7f7f7f, 64'h8080808080808080, 1'b1, 1'b1);
        get_result("T3_mix", -130048, 1, 1'b0, 0);
        send_beat(64'h0, 64'h0, 1'b1, 1'b1);
        get_result("T3_zero", 0, 1, 1'b0, 0);
        send_beat(64'h8080808080808080, 64'h8080808080808080, 1'b1, 1'b0);
        get_result("T3_raw_neg", beat_val(64'h8080808080808080, 64'h8080808080808080, 1'b0),
                   1, 1'b0, 0);

        // T2: random packets with gaps and back-pressure
        for (int p = 0; p < 100; p++) begin
            run_packet($urandom_range(1, MB), 1'($urandom), 2);
        end

        // T4: held result while a new beat is offered
        pa = {$urandom, $urandom}; pb = {$urandom, $urandom};
        qa = {$urandom, $urandom}; qb = {$urandom, $urandom};
        qm = 1'($urandom);
        exp_p = beat_val(pa, pb, 1'b1) + beat_val(qb, qa, 1'b1);
        send_beat(pa, pb, 1'b0, 1'b1);
        send_beat(qb, qa, 1'b1, 1'b0);
        in_0 = qa; in_1 = qb; in_last = 1'b1; mode_in = qm; in_valid = 1'b1;
        for (int w = 0; w < 50 && !out_valid; w++) tick();
        for (int i = 0; i < 10; i++) begin
            chk("T4_hold_valid", out_valid, 1);
            chk("T4_hold_out", $signed(out_o), exp_p);
            chk("T4_hold_beats", out_beats, 2);
            chk("T4_hold_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        send_beat(qa, qb, 1'b1, qm);
        get_result("T4_next", beat_val(qa, qb, qm), 1, 1'b0, 0);

        // T5: packet longer than MAX_BEATS is cut and resumed
        for (int i = 0; i < 4; i++) send_beat(ones, ones, 1'b0, 1'b1);
        get_result("T5_first", 32, 4, 1'b1, 2);
        send_beat(ones, ones, 1'b0, 1'b1);
        send_beat(ones, ones, 1'b1, 1'b0);
        get_result("T5_second", 16, 2, 1'b0, 0);

        // T6: asynchronous reset mid-packet
        send_beat(twos, twos, 1'b0, 1'b1);
        send_beat(twos, twos, 1'b0, 1'b1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("T6_rst_ready", in_ready, 1);
        chk("T6_rst_valid", out_valid, 0);
        chk("T6_rst_out", $signed(out_o), 0);
        tick();
        rst_ni = 1'b1;
        tick();
        send_beat(ones, twos, 1'b1, 1'b1);
        get_result("T6_after", 16, 1, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
